// File: rtl/background_ram_loader_pkg.sv
// Shared definitions for the background palette-index RAM loader.
// Holds the segment geometry, the widths of the host words and palette indices,
// the loader state encoding, and a helper that picks one index out of a packed host word.
package background_ram_loader_pkg;

    localparam int unsigned SEG_X_SIZE  = 640;   // pixels per segment row
    localparam int unsigned SEG_Y_SIZE  = 177;   // rows in the ground segment
    localparam int unsigned SEG_Y_START = 253;   // first screen row of the segment (renderer side)
    localparam int unsigned IDX_W       = 4;
    localparam int unsigned WORD_W      = 32;
    localparam int unsigned NIBS        = WORD_W / IDX_W;
    localparam int unsigned ADDR_W      = 17;
    localparam int unsigned ROW_W       = 8;
    localparam int unsigned COL_W       = 10;
    localparam int unsigned TOTAL_PIX   = SEG_X_SIZE * SEG_Y_SIZE;

    typedef logic [IDX_W-1:0]         pal_idx_t;
    typedef logic [WORD_W-1:0]        pix_word_t;
    typedef logic [$clog2(NIBS)-1:0]  nib_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_UNPACK,
        ST_DONE
    } loader_state_t;

    // Index n of a packed word; index 0 sits in bits [3:0] (lowest address).
    function automatic pal_idx_t word_nibble(input pix_word_t w, input nib_idx_t n);
        pix_word_t s;
        s = w >> (n * IDX_W);
        return s[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/background_ram_loader_if.sv
// Host-to-loader word stream: packed palette indices with a valid/ready handshake.
//   in_data  : 8 x 4-bit palette indices, bits [3:0] = lowest address
//   in_valid : in_data is valid
//   in_ready : loader takes in_data this cycle
// master = host side, slave = loader side.
interface background_ram_loader_if;
    import background_ram_loader_pkg::*;

    pix_word_t in_data;
    logic      in_valid;
    logic      in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/background_ram_loader_seg_addr_counter.sv
// Write-pointer for the ground segment: linear address plus column/row counters.
//   Clk, Reset : clock, asynchronous active-high reset
//   clr        : return the pointer to address 0
//   inc        : advance by one pixel (wraps to 0 after the last pixel)
//   addr, row  : pixel to be written next
//   last       : addr is the final pixel of the segment
module seg_addr_counter
    import background_ram_loader_pkg::*;
#(
    parameter int unsigned SEG_COLS = SEG_X_SIZE,
    parameter int unsigned SEG_ROWS = SEG_Y_SIZE
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr,
    output logic [ROW_W-1:0]  row,
    output logic              last
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SEG_COLS * SEG_ROWS - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(SEG_COLS - 1);

    logic [COL_W-1:0] col;

    assign last = (addr == LAST_ADDR);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            addr <= '0;
            col  <= '0;
            row  <= '0;
        end else if (clr || (inc && last)) begin
            addr <= '0;
            col  <= '0;
            row  <= '0;
        end else if (inc) begin
            addr <= addr + 1'b1;
            if (col == LAST_COL) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/background_ram_loader.sv
// Writer side of the background palette-index frame RAM.
// Takes packed 32-bit host words, unpacks them to one 4-bit index per clock and
// drives the RAM write port, filling the ground segment in raster order.
//   Clk, Reset : clock, asynchronous active-high reset
//   start      : pulse, begin a load at address 0 (ignored while busy or with abort)
//   abort      : pulse, cancel a load in progress (no done)
//   host       : word stream (in_data / in_valid / in_ready)
//   wr_en, wr_addr, wr_data : registered RAM write port, address = row*640 + col
//   cur_row    : row of the pixel on the write port
//   busy       : load in progress
//   done       : one-cycle pulse after the last pixel
module background_ram_loader
    import background_ram_loader_pkg::*;
#(
    parameter int unsigned SEG_COLS = SEG_X_SIZE,
    parameter int unsigned SEG_ROWS = SEG_Y_SIZE
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   start,
    input  logic                   abort,
    background_ram_loader_if.slave host,
    output logic                   wr_en,
    output logic [ADDR_W-1:0]      wr_addr,
    output pal_idx_t               wr_data,
    output logic [ROW_W-1:0]       cur_row,
    output logic                   busy,
    output logic                   done
);

    localparam nib_idx_t LAST_NIB = nib_idx_t'(NIBS - 1);

    loader_state_t     state;
    pix_word_t         word;
    nib_idx_t          nib;        // index currently shown on the write port
    logic              ready_q;
    logic              last_seen;  // final pixel of the segment has been emitted

    logic              running;
    logic              load_word;
    logic              step_nib;
    logic              emit;
    logic              cnt_clr;
    nib_idx_t          emit_nib;
    pal_idx_t          emit_data;
    logic [ADDR_W-1:0] cnt_addr;
    logic [ROW_W-1:0]  cnt_row;
    logic              cnt_last;

    assign host.in_ready = ready_q;

    always_comb begin
        running   = (state == ST_WAIT) || (state == ST_UNPACK);
        // ready_q is only ever set in WAIT or on the last index of an UNPACK word
        load_word = host.in_valid && ready_q && !abort;
        step_nib  = (state == ST_UNPACK) && !abort && (nib != LAST_NIB);
        emit      = load_word || step_nib;
        emit_nib  = load_word ? '0 : nib + 1'b1;
        emit_data = load_word ? word_nibble(host.in_data, '0) : word_nibble(word, emit_nib);
        cnt_clr   = ((state == ST_IDLE) && start && !abort) || (running && abort);
    end

    seg_addr_counter #(
        .SEG_COLS (SEG_COLS),
        .SEG_ROWS (SEG_ROWS)
    ) u_addr (
        .Clk   (Clk),
        .Reset (Reset),
        .clr   (cnt_clr),
        .inc   (emit),
        .addr  (cnt_addr),
        .row   (cnt_row),
        .last  (cnt_last)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= ST_IDLE;
            word      <= '0;
            nib       <= '0;
            ready_q   <= 1'b0;
            last_seen <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            cur_row   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;

            if (load_word) begin
                word <= host.in_data;
            end

            // ready is raised one cycle ahead so the next word lands right after index 7
            if (emit) begin
                wr_en   <= 1'b1;
                wr_data <= emit_data;
                wr_addr <= cnt_addr;
                cur_row <= cnt_row;
                nib     <= emit_nib;
                ready_q <= (emit_nib == LAST_NIB) && !cnt_last;
                if (cnt_last) begin
                    last_seen <= 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        state     <= ST_WAIT;
                        ready_q   <= 1'b1;
                        busy      <= 1'b1;
                        last_seen <= 1'b0;
                    end
                end
                ST_WAIT, ST_UNPACK: begin
                    if (abort) begin
                        state     <= ST_IDLE;
                        ready_q   <= 1'b0;
                        busy      <= 1'b0;
                        nib       <= '0;
                        last_seen <= 1'b0;
                    end else if (load_word) begin
                        state <= ST_UNPACK;
                    end else if ((state == ST_UNPACK) && !step_nib) begin
                        if (last_seen) begin
                            state   <= ST_DONE;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            ready_q <= 1'b0;
                        end else begin
                            state   <= ST_WAIT;
                            ready_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_background_ram_loader.sv
// Directed bench for background_ram_loader, run on a reduced 640x4 segment so a
// complete load fits in a short simulation; row wrap and the final pixel still occur.
module tb_background_ram_loader;

    localparam int unsigned TB_X     = 640;
    localparam int unsigned TB_Y     = 4;
    localparam int unsigned TB_TOTAL = TB_X * TB_Y;

    logic        Clk;
    logic        Reset;
    logic        start;
    logic        abort;
    logic        wr_en;
    logic [16:0] wr_addr;
    logic [3:0]  wr_data;
    logic [7:0]  cur_row;
    logic        busy;
    logic        done;

    background_ram_loader_if host_if ();

    background_ram_loader #(
        .SEG_COLS (TB_X),
        .SEG_ROWS (TB_Y)
    ) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .start   (start),
        .abort   (abort),
        .host    (host_if),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .cur_row (cur_row),
        .busy    (busy),
        .done    (done)
    );

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    int unsigned cyc = 0;
    bit          mon_en = 1;
    bit          nib_mode = 0;
    int unsigned exp_addr = 0;
    int unsigned wr_cnt = 0;
    int unsigned done_cnt = 0;
    int unsigned done_cyc = 0;
    int unsigned first_wr_cyc = 0;
    int unsigned last_wr_cyc = 0;
    int unsigned first_acc_cyc = 0;
    int unsigned last_addr = 0;
    int unsigned last_row = 0;
    int unsigned word_idx = 0;
    int unsigned d0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] gen_word(input int unsigned i);
        logic [3:0] n;
        n = i[3:0];
        if (nib_mode && i == 0) return 32'h7654_3210;
        return {8{n}};
    endfunction

    function automatic logic [3:0] exp_pix(input int unsigned a);
        logic [31:0] w;
        w = gen_word(a / 8) >> ((a % 8) * 4);
        return w[3:0];
    endfunction

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Write-port monitor: every write must follow the contiguous raster sequence.
    initial begin
        forever begin
            @(negedge Clk);
            cyc++;
            if (mon_en && wr_en) begin
                check_eq("wr_addr", wr_addr, exp_addr);
                check_eq("cur_row", cur_row, exp_addr / TB_X);
                check_eq("wr_data", wr_data, exp_pix(exp_addr));
                check_eq("in_ready_n7", host_if.in_ready,
                         (exp_addr % 8 == 7) && (exp_addr != TB_TOTAL - 1));
                if (wr_cnt == 0) first_wr_cyc = cyc;
                last_wr_cyc = cyc;
                last_addr = wr_addr;
                last_row = cur_row;
                exp_addr++;
                wr_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check_eq("busy_at_done", busy, 0);
            end
        end
    end

    task automatic run_load(input int unsigned gap_pct, input int unsigned abort_word,
                            input int unsigned dup_start_word);
        int unsigned d_start;
        int unsigned n;
        bit stop;
        d_start = done_cnt;
        n = 0;
        stop = 0;
        word_idx = 0;
        exp_addr = 0;
        wr_cnt = 0;
        @(negedge Clk);
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        while (!stop && n < 4 * TB_TOTAL) begin
            host_if.in_valid = ($urandom_range(99) >= gap_pct);
            host_if.in_data  = gen_word(word_idx);
            start = (dup_start_word != 0) && (word_idx == dup_start_word);
            abort = 1'b0;
            if (abort_word != 0 && word_idx == abort_word && host_if.in_ready) begin
                abort = 1'b1;
                host_if.in_valid = 1'b1;
                stop = 1;
            end
            @(posedge Clk);
            if (!abort && host_if.in_valid && host_if.in_ready) begin
                if (word_idx == 0) first_acc_cyc = cyc;
                word_idx++;
            end
            @(negedge Clk);
            if (done_cnt != d_start) stop = 1;
            n++;
        end
        host_if.in_valid = 1'b0;
        abort = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        host_if.in_valid = 1'b0;
        host_if.in_data  = '0;

        // Reset state
        repeat (2) @(negedge Clk);
        check_eq("rst_wr_en", wr_en, 0);
        check_eq("rst_wr_addr", wr_addr, 0);
        check_eq("rst_wr_data", wr_data, 0);
        check_eq("rst_cur_row", cur_row, 0);
        check_eq("rst_in_ready", host_if.in_ready, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        Reset = 1'b0;

        // start together with abort in IDLE is ignored; lone abort in IDLE does nothing
        @(negedge Clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        abort = 1'b0;
        check_eq("start_abort_busy", busy, 0);
        check_eq("start_abort_ready", host_if.in_ready, 0);
        abort = 1'b1;
        @(negedge Clk);
        abort = 1'b0;
        check_eq("idle_abort_busy", busy, 0);

        // Full load, back-to-back words
        d0 = done_cnt;
        run_load(0, 0, 0);
        check_eq("full_writes", wr_cnt, TB_TOTAL);
        check_eq("full_done_cnt", done_cnt - d0, 1);
        check_eq("done_latency", done_cyc - first_acc_cyc, TB_TOTAL + 1);
        check_eq("no_bubble_span", last_wr_cyc - first_wr_cyc + 1, TB_TOTAL);
        check_eq("last_addr", last_addr, TB_TOTAL - 1);
        check_eq("last_row", last_row, TB_Y - 1);
        // extra host words after the last pixel are never taken
        host_if.in_valid = 1'b1;
        host_if.in_data  = 32'hFFFF_FFFF;
        repeat (8) @(negedge Clk);
        check_eq("extra_ready", host_if.in_ready, 0);
        check_eq("extra_writes", wr_cnt, TB_TOTAL);
        check_eq("extra_busy", busy, 0);
        host_if.in_valid = 1'b0;

        // Nibble order on word 0, then abort with a same-cycle accept
        nib_mode = 1;
        d0 = done_cnt;
        run_load(0, 100, 0);
        check_eq("abort_wr_en", wr_en, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_ready", host_if.in_ready, 0);
        check_eq("abort_writes", wr_cnt, 800);
        check_eq("abort_hold_addr", wr_addr, 799);
        repeat (5) @(negedge Clk);
        check_eq("abort_no_done", done_cnt - d0, 0);
        check_eq("abort_still_idle", wr_en, 0);
        nib_mode = 0;

        // Asynchronous reset in the middle of unpacking
        mon_en = 0;
        d0 = done_cnt;
        @(negedge Clk);
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        host_if.in_valid = 1'b1;
        host_if.in_data  = 32'h1234_5678;
        repeat (20) @(posedge Clk);
        #1;
        check_eq("pre_rst_wr_en", wr_en, 1);
        check_eq("pre_rst_busy", busy, 1);
        #2 Reset = 1'b1;
        #1;
        check_eq("arst_wr_en", wr_en, 0);
        check_eq("arst_wr_addr", wr_addr, 0);
        check_eq("arst_wr_data", wr_data, 0);
        check_eq("arst_cur_row", cur_row, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_ready", host_if.in_ready, 0);
        host_if.in_valid = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check_eq("arst_no_done", done_cnt - d0, 0);
        mon_en = 1;

        // Load with random in_valid gaps and a stray start while busy
        d0 = done_cnt;
        run_load(30, 0, 5);
        check_eq("gap_writes", wr_cnt, TB_TOTAL);
        check_eq("gap_done_cnt", done_cnt - d0, 1);
        check_eq("gap_last_addr", last_addr, TB_TOTAL - 1);
        check_eq("gap_last_row", last_row, TB_Y - 1);

        repeat (2) @(negedge Clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
